// File: rtl/axi_4_vlsu_req_sequencer_pkg.sv
// Shared types and constants for the VLSU request sequencer.
// Holds beat/page geometry, the AXI burst encoding and the sequencer FSM state type.
package axi_4_vlsu_req_sequencer_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned BURST_MAX_DEF = 8;
    localparam int unsigned CNT_W_DEF     = 16;

    localparam int unsigned BEAT_BYTES   = 8;
    localparam int unsigned PAGE_BYTES   = 4096;
    localparam int unsigned STROBE_WIDTH = DATA_W_DEF / 8;

    localparam logic [2:0] BURST_SIZE_8B = 3'd3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_type_e;

    typedef enum logic [3:0] {
        StIdle,
        StCalc,
        StWfill,
        StWissue,
        StWwait,
        StRissue,
        StRwait,
        StRdrain,
        StFin
    } seq_state_e;

    // Width needed to hold a beat count in 0..burst_max.
    function automatic int unsigned burst_cnt_w(input int unsigned burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/axi_4_vlsu_req_sequencer_if.sv
// Bundle of VLSU-side request/data streams and master-side burst signals.
// The master modport is the sequencer's view; slave is the environment's view.
interface axi_4_vlsu_req_sequencer_if
    import axi_4_vlsu_req_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
);

    logic                              req_valid;
    logic                              req_ready;
    logic                              req_we;
    logic [ADDR_W-1:0]                 req_addr;
    logic [CNT_W-1:0]                  req_beats;

    logic                              wdata_valid;
    logic                              wdata_ready;
    logic [DATA_W-1:0]                 wdata;

    logic                              rdata_valid;
    logic                              rdata_ready;
    logic [DATA_W-1:0]                 rdata;

    logic                              done;
    logic                              err;

    logic                              ld_req;
    logic                              st_req;
    logic [ADDR_W-1:0]                 base_addr;
    logic [7:0]                        burst_len;
    logic [2:0]                        burst_size;
    logic [1:0]                        burst_type;
    logic [DATA_W*BURST_MAX-1:0]       vlsu_wdata;
    logic [(DATA_W/8)*BURST_MAX-1:0]   write_strobe;
    logic [DATA_W*BURST_MAX-1:0]       burst_rdata_array;
    logic                              burst_valid_data;
    logic                              burst_wr_valid;

    modport master (
        input  req_valid, req_we, req_addr, req_beats,
        input  wdata_valid, wdata, rdata_ready,
        input  burst_rdata_array, burst_valid_data, burst_wr_valid,
        output req_ready, wdata_ready, rdata_valid, rdata, done, err,
        output ld_req, st_req, base_addr, burst_len, burst_size, burst_type,
        output vlsu_wdata, write_strobe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_beats,
        output wdata_valid, wdata, rdata_ready,
        output burst_rdata_array, burst_valid_data, burst_wr_valid,
        input  req_ready, wdata_ready, rdata_valid, rdata, done, err,
        input  ld_req, st_req, base_addr, burst_len, burst_size, burst_type,
        input  vlsu_wdata, write_strobe
    );

endinterface

// File: rtl/axi_4_vlsu_req_sequencer_burst_calc.sv
// Beat count of the next burst: min(remaining, BURST_MAX, beats left in the 4 KB page).
// Purely combinational; the caller guarantees a beat-aligned page offset.
module axi_4_vlsu_req_sequencer_burst_calc
    import axi_4_vlsu_req_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned N_W       = burst_cnt_w(BURST_MAX)
) (
    input  logic [$clog2(PAGE_BYTES)-1:0] page_off,
    input  logic [CNT_W-1:0]              remaining,
    output logic [N_W-1:0]                n
);

    localparam int unsigned OffW      = $clog2(PAGE_BYTES);
    localparam int unsigned BeatShift = $clog2(BEAT_BYTES);

    logic [OffW:0] page_room;
    logic [31:0]   page_beats;
    logic [31:0]   lim;

    // One extra bit so a zero offset yields a full page rather than wrapping to 0.
    assign page_room  = (OffW + 1)'(PAGE_BYTES) - {1'b0, page_off};
    assign page_beats = 32'(page_room) >> BeatShift;

    always_comb begin
        lim = BURST_MAX;
        if (page_beats < lim) lim = page_beats;
        if (32'(remaining) < lim) lim = 32'(remaining);
    end

    assign n = N_W'(lim);

endmodule

// File: rtl/axi_4_vlsu_req_sequencer.sv
// Splits one VLSU vector request into 4 KB-safe INCR bursts for axi_4_master,
// gathering write beats into a burst buffer and streaming read bursts back beat by beat.
module axi_4_vlsu_req_sequencer
    import axi_4_vlsu_req_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input logic                          clk,
    input logic                          reset,
    axi_4_vlsu_req_sequencer_if.master   bus
);

    localparam int unsigned N_W       = burst_cnt_w(BURST_MAX);
    localparam int unsigned StrbW     = DATA_W / 8;
    localparam int unsigned WBufW     = DATA_W * BURST_MAX;
    localparam int unsigned SBufW     = StrbW * BURST_MAX;
    localparam int unsigned WOffW     = $clog2(WBufW);
    localparam int unsigned SOffW     = $clog2(SBufW);
    localparam int unsigned OffW      = $clog2(PAGE_BYTES);
    localparam int unsigned AlignW    = $clog2(BEAT_BYTES);

    seq_state_e          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    remaining_q;
    logic                we_q;
    logic                err_lat_q;
    logic [N_W-1:0]      burst_n_q;
    logic [N_W-1:0]      beat_idx_q;
    logic [WBufW-1:0]    rbuf_q;

    logic                req_ready_q;
    logic                wdata_ready_q;
    logic                rdata_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                err_q;
    logic                ld_req_q;
    logic                st_req_q;
    logic [ADDR_W-1:0]   base_addr_q;
    logic [7:0]          burst_len_q;
    logic [WBufW-1:0]    vlsu_wdata_q;
    logic [SBufW-1:0]    write_strobe_q;

    logic [N_W-1:0]      calc_n;
    logic [N_W-1:0]      last_idx;
    logic [N_W-1:0]      next_idx;
    logic [WOffW-1:0]    wr_off;
    logic [WOffW-1:0]    rd_off;
    logic [SOffW-1:0]    st_off;
    logic [ADDR_W-1:0]   next_addr;
    logic                last_burst;

    axi_4_vlsu_req_sequencer_burst_calc #(
        .CNT_W     (CNT_W),
        .BURST_MAX (BURST_MAX),
        .N_W       (N_W)
    ) u_burst_calc (
        .page_off  (addr_q[OffW-1:0]),
        .remaining (remaining_q),
        .n         (calc_n)
    );

    assign last_idx   = burst_n_q - N_W'(1);
    assign next_idx   = beat_idx_q + N_W'(1);
    assign wr_off     = WOffW'(beat_idx_q) * WOffW'(DATA_W);
    assign rd_off     = WOffW'(next_idx) * WOffW'(DATA_W);
    assign st_off     = SOffW'(beat_idx_q) * SOffW'(StrbW);
    assign next_addr  = addr_q + (ADDR_W'(burst_n_q) << AlignW);
    assign last_burst = (remaining_q == CNT_W'(burst_n_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            remaining_q    <= '0;
            we_q           <= 1'b0;
            err_lat_q      <= 1'b0;
            burst_n_q      <= '0;
            beat_idx_q     <= '0;
            rbuf_q         <= '0;
            req_ready_q    <= 1'b1;
            wdata_ready_q  <= 1'b0;
            rdata_valid_q  <= 1'b0;
            rdata_q        <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            ld_req_q       <= 1'b0;
            st_req_q       <= 1'b0;
            base_addr_q    <= '0;
            burst_len_q    <= '0;
            vlsu_wdata_q   <= '0;
            write_strobe_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // done/err pulse ends here; ready returns one cycle after done.
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= bus.req_addr;
                        remaining_q <= bus.req_beats;
                        we_q        <= bus.req_we;
                        err_lat_q   <= 1'b0;
                        if (bus.req_addr[AlignW-1:0] != '0) begin
                            err_lat_q <= 1'b1;
                            state_q   <= StFin;
                        end else if (bus.req_beats == '0) begin
                            state_q <= StFin;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    burst_n_q   <= calc_n;
                    base_addr_q <= addr_q;
                    burst_len_q <= 8'(calc_n - N_W'(1));
                    beat_idx_q  <= '0;
                    if (we_q) begin
                        vlsu_wdata_q   <= '0;
                        write_strobe_q <= '0;
                        wdata_ready_q  <= 1'b1;
                        state_q        <= StWfill;
                    end else begin
                        ld_req_q <= 1'b1;
                        state_q  <= StRissue;
                    end
                end
                StWfill: begin
                    if (bus.wdata_valid && wdata_ready_q) begin
                        vlsu_wdata_q[wr_off +: DATA_W]  <= bus.wdata;
                        write_strobe_q[st_off +: StrbW] <= '1;
                        if (beat_idx_q == last_idx) begin
                            wdata_ready_q <= 1'b0;
                            st_req_q      <= 1'b1;
                            state_q       <= StWissue;
                        end else begin
                            beat_idx_q <= next_idx;
                        end
                    end
                end
                StWissue: begin
                    st_req_q <= 1'b0;
                    state_q  <= StWwait;
                end
                StWwait: begin
                    if (bus.burst_wr_valid) begin
                        addr_q      <= next_addr;
                        remaining_q <= remaining_q - CNT_W'(burst_n_q);
                        state_q     <= last_burst ? StFin : StCalc;
                    end
                end
                StRissue: begin
                    ld_req_q <= 1'b0;
                    state_q  <= StRwait;
                end
                StRwait: begin
                    if (bus.burst_valid_data) begin
                        rbuf_q        <= bus.burst_rdata_array;
                        rdata_q       <= bus.burst_rdata_array[DATA_W-1:0];
                        rdata_valid_q <= 1'b1;
                        beat_idx_q    <= '0;
                        state_q       <= StRdrain;
                    end
                end
                StRdrain: begin
                    if (bus.rdata_ready) begin
                        if (beat_idx_q == last_idx) begin
                            rdata_valid_q <= 1'b0;
                            addr_q        <= next_addr;
                            remaining_q   <= remaining_q - CNT_W'(burst_n_q);
                            state_q       <= last_burst ? StFin : StCalc;
                        end else begin
                            beat_idx_q <= next_idx;
                            rdata_q    <= rbuf_q[rd_off +: DATA_W];
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    err_q   <= err_lat_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.wdata_ready  = wdata_ready_q;
    assign bus.rdata_valid  = rdata_valid_q;
    assign bus.rdata        = rdata_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.ld_req       = ld_req_q;
    assign bus.st_req       = st_req_q;
    assign bus.base_addr    = base_addr_q;
    assign bus.burst_len    = burst_len_q;
    assign bus.burst_size   = BURST_SIZE_8B;
    assign bus.burst_type   = BURST_INCR;
    assign bus.vlsu_wdata   = vlsu_wdata_q;
    assign bus.write_strobe = write_strobe_q;

endmodule

// File: tb/tb_axi_4_vlsu_req_sequencer.sv
// Directed bench for axi_4_vlsu_req_sequencer with a small memory-backed slave model.
module tb_axi_4_vlsu_req_sequencer;

    logic clk;
    logic reset;

    axi_4_vlsu_req_sequencer_if bus ();

    axi_4_vlsu_req_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;

    logic [63:0] mem [logic [31:0]];
    logic [63:0] wq [$];
    logic [31:0] ld_base [$];
    logic [7:0]  ld_len [$];
    logic [31:0] st_base [$];
    logic [7:0]  st_len [$];
    logic [63:0] rd_q [$];
    int          ld_cnt, st_cnt, done_cnt, done_lat;
    logic        done_err, ready_at_done, ready_after;
    logic [511:0] last_wdata;
    logic [63:0]  last_strb;
    int          stall_at;

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {32'h5EED0000, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [15:0] beats);
        int cyc, budget, rsp_t, stall_left;
        logic hs, hsw, hsr, rsp_pend, rsp_load, stalled_once;
        logic [63:0] held, r;
        logic [511:0] arr;
        ld_base.delete(); ld_len.delete(); st_base.delete(); st_len.delete(); rd_q.delete();
        ld_cnt = 0; st_cnt = 0; done_cnt = 0; done_lat = 0; done_err = 1'bx;
        ready_at_done = 1'bx; rsp_pend = 0; rsp_load = 0; rsp_t = 0;
        stall_left = 0; stalled_once = 0; held = '0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_beats = beats;
        budget = 0;
        do begin
            hs = bus.req_valid && bus.req_ready;
            tick();
            budget++;
        end while (!hs && budget < 20);
        bus.req_valid = 1'b0;
        if (!hs) begin
            check("accept_timeout", 1'b0, 1'b1);
            return;
        end
        cyc = 1;
        while (done_cnt == 0 && cyc < 2000) begin
            if (bus.ld_req) begin
                ld_cnt++; ld_base.push_back(bus.base_addr); ld_len.push_back(bus.burst_len);
                rsp_pend = 1; rsp_load = 1; rsp_t = 2;
            end
            if (bus.st_req) begin
                st_cnt++; st_base.push_back(bus.base_addr); st_len.push_back(bus.burst_len);
                last_wdata = bus.vlsu_wdata; last_strb = bus.write_strobe;
                for (int i = 0; i < 8; i++)
                    if (bus.write_strobe[8*i]) mem[bus.base_addr + 32'(8*i)] = bus.vlsu_wdata[64*i +: 64];
                rsp_pend = 1; rsp_load = 0; rsp_t = 2;
            end
            if (bus.done) begin
                done_cnt++; done_lat = cyc; done_err = bus.err; ready_at_done = bus.req_ready;
            end
            bus.burst_valid_data = 1'b0;
            bus.burst_wr_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_t == 0) begin
                    rsp_pend = 0;
                    if (rsp_load) begin
                        arr = '0;
                        for (int i = 0; i <= int'(ld_len[$]); i++)
                            arr[64*i +: 64] = mem_rd(ld_base[$] + 32'(8*i));
                        bus.burst_rdata_array = arr;
                        bus.burst_valid_data = 1'b1;
                    end else begin
                        bus.burst_wr_valid = 1'b1;
                    end
                end else begin
                    rsp_t--;
                end
            end
            bus.wdata_valid = (wq.size() > 0);
            bus.wdata = (wq.size() > 0) ? wq[0] : 64'h0;
            if (bus.rdata_valid && rd_q.size() == stall_at && !stalled_once) begin
                stalled_once = 1; stall_left = 5; held = bus.rdata;
            end
            if (stall_left > 0) begin
                if (stall_left < 5) check("rdata_stable", bus.rdata, held);
                stall_left--;
                bus.rdata_ready = 1'b0;
            end else begin
                bus.rdata_ready = 1'b1;
            end
            hsw = bus.wdata_valid && bus.wdata_ready;
            hsr = bus.rdata_valid && bus.rdata_ready;
            r = bus.rdata;
            tick();
            cyc++;
            if (hsw) void'(wq.pop_front());
            if (hsr) rd_q.push_back(r);
        end
        bus.burst_valid_data = 1'b0;
        bus.burst_wr_valid = 1'b0;
        bus.wdata_valid = 1'b0;
        bus.rdata_ready = 1'b1;
        ready_after = bus.req_ready;
        if (done_cnt == 0) check("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        compared = 0; mismatched = 0; stall_at = -1;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_beats = '0;
        bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 1;
        bus.burst_rdata_array = '0; bus.burst_valid_data = 0; bus.burst_wr_valid = 0;
        reset = 1;
        repeat (3) tick();
        reset = 0;

        // Reset state
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_done", bus.done, 1'b0);
        check("rst_ld_req", bus.ld_req, 1'b0);
        check("rst_burst_size", bus.burst_size, 3'd3);
        check("rst_burst_type", bus.burst_type, 2'b01);
        check("rst_wdata", bus.vlsu_wdata, 512'h0);
        check("rst_rdata_valid", bus.rdata_valid, 1'b0);

        // Store 4 beats at 0x100
        for (int k = 0; k < 4; k++) wq.push_back(64'hCAFEBABE00000001 + 64'(k));
        run_req(1'b1, 32'h100, 16'd4);
        check("st_count", st_cnt, 1);
        check("st_no_ld", ld_cnt, 0);
        if (st_cnt == 1) begin
            check("st_base", st_base[0], 32'h100);
            check("st_len", st_len[0], 8'd3);
        end
        check("st_strobe", last_strb, 64'h00000000FFFFFFFF);
        check("st_upper_zero", last_wdata[511:256], 256'h0);
        check("st_mem0", mem_rd(32'h100), 64'hCAFEBABE00000001);
        check("st_mem3", mem_rd(32'h118), 64'hCAFEBABE00000004);
        check("st_done", done_cnt, 1);
        check("st_err", done_err, 1'b0);
        check("st_wq_empty", wq.size(), 0);

        // Load 20 beats at 0x100: three bursts, first four beats read back the store
        run_req(1'b0, 32'h100, 16'd20);
        check("ld20_bursts", ld_cnt, 3);
        if (ld_cnt == 3) begin
            check("ld20_base0", ld_base[0], 32'h100);
            check("ld20_base1", ld_base[1], 32'h140);
            check("ld20_base2", ld_base[2], 32'h180);
            check("ld20_len0", ld_len[0], 8'd7);
            check("ld20_len1", ld_len[1], 8'd7);
            check("ld20_len2", ld_len[2], 8'd3);
        end
        check("ld20_beats", rd_q.size(), 20);
        for (int k = 0; k < rd_q.size(); k++) begin
            if (k < 4) check("ld20_data", rd_q[k], 64'hCAFEBABE00000001 + 64'(k));
            else check("ld20_data", rd_q[k], {32'h5EED0000, 32'h100 + 32'(8*k)});
        end
        check("ld20_err", done_err, 1'b0);

        // Load 4 beats at 0xFF0: split at the 4 KB boundary
        run_req(1'b0, 32'hFF0, 16'd4);
        check("pg_bursts", ld_cnt, 2);
        if (ld_cnt == 2) begin
            check("pg_base0", ld_base[0], 32'hFF0);
            check("pg_len0", ld_len[0], 8'd1);
            check("pg_base1", ld_base[1], 32'h1000);
            check("pg_len1", ld_len[1], 8'd1);
        end
        check("pg_beats", rd_q.size(), 4);
        for (int k = 0; k < rd_q.size(); k++)
            check("pg_data", rd_q[k], {32'h5EED0000, 32'hFF0 + 32'(8*k)});

        // Zero beats: done two cycles after accept, no traffic
        run_req(1'b0, 32'h200, 16'd0);
        check("z_lat", done_lat, 2);
        check("z_err", done_err, 1'b0);
        check("z_traffic", ld_cnt + st_cnt, 0);
        check("z_ready_at_done", ready_at_done, 1'b0);
        check("z_ready_after", ready_after, 1'b1);

        // Misaligned store: err, no traffic, no write beats consumed
        wq.push_back(64'h1111); wq.push_back(64'h2222);
        run_req(1'b1, 32'h104, 16'd2);
        check("mis_err", done_err, 1'b1);
        check("mis_traffic", ld_cnt + st_cnt, 0);
        check("mis_wq", wq.size(), 2);
        wq.delete();

        // Reset while waiting for read data
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h300; bus.req_beats = 16'd4;
        tick();
        bus.req_valid = 0;
        tick();
        check("rw_ld_req", bus.ld_req, 1'b1);
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        check("rw_ready", bus.req_ready, 1'b1);
        check("rw_done", bus.done, 1'b0);
        check("rw_ld_clr", bus.ld_req, 1'b0);
        bus.burst_valid_data = 1;
        tick();
        bus.burst_valid_data = 0;
        check("stray_rvalid", bus.rdata_valid, 1'b0);
        check("stray_done", bus.done, 1'b0);

        // Fresh load with a 5-cycle consumer stall on beat 1
        stall_at = 1;
        run_req(1'b0, 32'h300, 16'd4);
        stall_at = -1;
        check("rl_bursts", ld_cnt, 1);
        check("rl_beats", rd_q.size(), 4);
        for (int k = 0; k < rd_q.size(); k++)
            check("rl_data", rd_q[k], {32'h5EED0000, 32'h300 + 32'(8*k)});
        check("rl_err", done_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
